// File: rtl/nibble_pkg.sv
// nibble_pkg: shared widths and the buffered word type for the nibble packer.
//   NIB_W     - width of one input nibble
//   WORD_NIBS - nibbles per packed output word
//   WORD_W    - packed output word width
//   word_t    - one output buffer entry {data, last}
package nibble_pkg;
    localparam int NIB_W     = 4;
    localparam int WORD_NIBS = 4;
    localparam int WORD_W    = 16;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
    } word_t;
endpackage

// File: rtl/nibble_packer_if.sv
// nibble_packer_if: nibble input stream and packed word output stream.
//   in / in_valid / in_last / in_ready      - upstream nibble handshake
//   out / out_last / out_valid / out_ready  - downstream word handshake
// slave  : the packer side
// master : the side that feeds nibbles and consumes words
interface nibble_packer_if;
    import nibble_pkg::*;

    logic [NIB_W-1:0]  in;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [WORD_W-1:0] out;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in, in_valid, in_last, out_ready,
        output in_ready, out, out_last, out_valid
    );

    modport master (
        output in, in_valid, in_last, out_ready,
        input  in_ready, out, out_last, out_valid
    );
endinterface

// File: rtl/nibble_fifo.sv
// nibble_fifo: small word_t FIFO used as the packer's output buffer.
//   clk, rst   - clock, async active-high reset (clears storage too)
//   push/pop   - write / read strobes; push+pop on the same edge keeps count
//   push_data  - entry to write
//   head       - entry at the read pointer (all zeros after reset)
//   full/empty/count - occupancy
module nibble_fifo
    import nibble_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  word_t                        push_data,
    input  logic                         pop,
    output word_t                        head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    word_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // Pointers wrap explicitly so non power-of-two depths work.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO may still take a push.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/nibble_packer.sv
// nibble_packer: packs a nibble stream LSB-first into 16-bit words and
// buffers finished words in nibble_fifo.
//   clk, rst - clock, async active-high reset
//   bus      - nibble_packer_if.slave (nibble in, word out handshakes)
// A word completes on its 4th nibble or on any nibble flagged in_last; an
// early word is zero-filled above the last written nibble and marked last.
module nibble_packer
    import nibble_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    nibble_packer_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0]                       cnt_q;
    logic [WORD_NIBS-1:0][NIB_W-1:0]  asm_q, asm_next;
    logic                             accept, completing, complete;
    logic                             fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]                    fifo_count;
    word_t                            push_word, fifo_head;

    // Only completing nibbles need a FIFO slot; out_ready is deliberately
    // kept out of this term so in_ready has no combinational path from it.
    assign completing   = (cnt_q == 2'd3) || bus.in_last;
    assign bus.in_ready = !(fifo_full && completing);
    assign accept       = bus.in_valid && bus.in_ready;
    assign complete     = accept && completing;

    // The assembly register is cleared after every word, so the upper
    // nibbles of an early-terminated word are already zero.
    always_comb begin
        asm_next        = asm_q;
        asm_next[cnt_q] = bus.in;
    end

    assign push_word.data = asm_next;
    assign push_word.last = bus.in_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else if (accept) begin
            if (completing) begin
                cnt_q <= '0;
                asm_q <= '0;
            end else begin
                cnt_q <= cnt_q + 2'd1;
                asm_q <= asm_next;
            end
        end
    end

    assign fifo_pop = !fifo_empty && bus.out_ready;

    nibble_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (complete),
        .push_data (push_word),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.out_valid = (fifo_count != '0);
    assign bus.out       = fifo_head.data;
    assign bus.out_last  = fifo_head.last;
endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: scenario tasks drive nibbles and push expected words into
// a scoreboard queue; a monitor pops and compares on each output handshake.
module tb_nibble_packer;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    logic [16:0] exp_q[$];

    nibble_packer_if bus();

    nibble_packer #(.FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare each word taken by the downstream handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL word_unexpected: got %h/%b, none expected", bus.out, bus.out_last);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({bus.out, bus.out_last} !== e)
                    $display("FAIL word_order: got %h/%b, want %h/%b", bus.out, bus.out_last, e[16:1], e[0]);
                else
                    pass_cnt++;
            end
        end
    end

    // Present one nibble until accepted (bounded); returns #1 after the accepting edge.
    task automatic send(input logic [3:0] nib, input logic last);
        logic rdy;
        int   n;
        n = 0;
        bus.in       = nib;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        do begin
            rdy = bus.in_ready;
            @(posedge clk);
            n++;
            if (!rdy) #1;
        end while (!rdy && n < 100);
        if (!rdy) begin
            total_cnt++;
            $display("FAIL send_timeout: nibble %h not accepted in %0d cycles", nib, n);
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++;
        if (bus.out !== 16'h0) $display("FAIL rst_out: got %h want 0000", bus.out); else pass_cnt++;
        total_cnt++;
        if (bus.out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", bus.out_last); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL post_rst_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s_drain: %0d words still expected, want 0", name, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_basic_pack();
        bus.out_ready = 1'b1;
        exp_q.push_back({16'h4321, 1'b0});
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL basic_latency: out_valid %b want 1", bus.out_valid); else pass_cnt++;
        total_cnt++;
        if (bus.out !== 16'h4321) $display("FAIL basic_out: got %h want 4321", bus.out); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_single_cycle: out_valid %b want 0", bus.out_valid); else pass_cnt++;
        drain("basic");
    endtask

    task automatic test_early_last();
        bus.out_ready = 1'b1;
        exp_q.push_back({16'h00BA, 1'b1});
        exp_q.push_back({16'h8765, 1'b0});
        send(4'hA, 1'b0); send(4'hB, 1'b1);
        send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0); send(4'h8, 1'b0);
        drain("early_last");
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        exp_q.push_back({16'h3210, 1'b0});
        exp_q.push_back({16'h7654, 1'b0});
        exp_q.push_back({16'hBA98, 1'b0});
        for (int i = 0; i < 8; i++) send(4'(i), 1'b0);
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_full_cnt0: got %b want 1", bus.in_ready); else pass_cnt++;
        for (int i = 8; i < 11; i++) send(4'(i), 1'b0);
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_full_cnt3: got %b want 0", bus.in_ready); else pass_cnt++;
        bus.in = 4'hB;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out !== 16'h3210)
                $display("FAIL bp_stall: ready %b valid %b out %h, want 0 1 3210", bus.in_ready, bus.out_valid, bus.out);
            else pass_cnt++;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(4'hB, 1'b0);
        drain("backpressure");
    endtask

    task automatic test_full_pushpop();
        bus.out_ready = 1'b0;
        exp_q.push_back({16'h4321, 1'b0});
        exp_q.push_back({16'h8765, 1'b0});
        exp_q.push_back({16'hCBA9, 1'b0});
        for (int i = 1; i < 12; i++) send(4'(i), 1'b0);
        bus.in = 4'hC;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL pp_no_ready_path: got %b want 0", bus.in_ready); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL pp_ready_after_pop: got %b want 1", bus.in_ready); else pass_cnt++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain("pushpop");
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL pp_idle_after: out_valid %b want 0", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_word();
        bus.out_ready = 1'b0;
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
        send(4'h5, 1'b0); send(4'h6, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out !== 16'h0 || bus.out_last !== 1'b0)
            $display("FAIL rst_mid_outputs: valid %b out %h last %b, want 0 0000 0", bus.out_valid, bus.out, bus.out_last);
        else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        exp_q.push_back({16'hA987, 1'b0});
        send(4'h7, 1'b0); send(4'h8, 1'b0); send(4'h9, 1'b0); send(4'hA, 1'b0);
        drain("rst_mid");
    endtask

    task automatic test_idle_gaps();
        logic [3:0] nibs [4];
        nibs = '{4'hC, 4'hD, 4'hE, 4'hF};
        bus.out_ready = 1'b1;
        exp_q.push_back({16'hFEDC, 1'b0});
        for (int i = 0; i < 4; i++) begin
            send(nibs[i], 1'b0);
            for (int g = 0; g < 2; g++) begin
                bus.in      = 4'($urandom_range(0, 15));
                bus.in_last = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            bus.in_last = 1'b0;
        end
        drain("idle_gaps");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic_pack();
        test_early_last();
        test_backpressure();
        test_full_pushpop();
        test_reset_mid_word();
        test_idle_gaps();
        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
